// File: rtl/regfile_mp_pkg.sv
// Shared core-wide widths and the hard-wired zero register index for the MIPS register file.
package regfile_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_TAG_W  = 4;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy/tag table: issue/flush/writeback-clear priority and the read-side busy bypass.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  input  logic [NWRITE-1:0]         we,
  input  logic [NWRITE*ADDR_W-1:0]  waddr,
  input  logic [NWRITE*TAG_W-1:0]   wtag,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [TAG_W-1:0]          issue_tag,
  input  logic                      flush,
  output logic [NREAD-1:0]          rbusy,
  output logic [NREAD*TAG_W-1:0]    rtag
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  busy_r;
  logic [TAG_W-1:0]  tag_r [DEPTH];
  logic [DEPTH-1:0]  clear_s;
  logic              issue_ok_s;

  assign issue_ok_s = issue_en && (issue_addr != ADDR_W'(REG_ZERO));

  // Registers whose outstanding producer (tag match) writes back this cycle.
  always_comb begin
    clear_s = '0;
    for (int i = 0; i < NWRITE; i++) begin
      clear_s[waddr[i*ADDR_W +: ADDR_W]] = clear_s[waddr[i*ADDR_W +: ADDR_W]] |
        (we[i] && (wtag[i*TAG_W +: TAG_W] == tag_r[waddr[i*ADDR_W +: ADDR_W]]));
    end
  end

  // Busy/tag table update; the issue assignment comes last so it overrides a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
      for (int r = 0; r < DEPTH; r++) tag_r[r] <= '0;
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_r & ~clear_s;
      if (issue_ok_s) begin
        busy_r[issue_addr] <= 1'b1;
        tag_r[issue_addr]  <= issue_tag;
      end
    end
  end

  // Read side: a matching writeback in flight already counts as resolved.
  always_comb begin
    rbusy = '0;
    rtag  = '0;
    for (int j = 0; j < NREAD; j++) begin
      rbusy[j] = busy_r[raddr[j*ADDR_W +: ADDR_W]] & ~clear_s[raddr[j*ADDR_W +: ADDR_W]];
      rtag[j*TAG_W +: TAG_W] = tag_r[raddr[j*ADDR_W +: ADDR_W]];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, reset preload and a per-register scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NREAD       = 4,
  parameter int NWRITE      = 2,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int PRELOAD_REG = 2,
  parameter int ARG_W       = 5,
  parameter int TEST_REG    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ARG_W-1:0]          arguments,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  output logic [NREAD*DATA_W-1:0]   rdata,
  output logic [NREAD-1:0]          rbusy,
  output logic [NREAD*TAG_W-1:0]    rtag,
  input  logic [NWRITE-1:0]         we,
  input  logic [NWRITE*ADDR_W-1:0]  waddr,
  input  logic [NWRITE*DATA_W-1:0]  wdata,
  input  logic [NWRITE*TAG_W-1:0]   wtag,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [TAG_W-1:0]          issue_tag,
  input  logic                      flush,
  output logic [DATA_W-1:0]         test_result
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] ra_s;
  logic [ADDR_W-1:0] wa_s;
  logic [DATA_W-1:0] rd_s;

  // Data array: ascending port order so the highest-index writer lands last; reg 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem_r[r] <= '0;
      mem_r[PRELOAD_REG] <= DATA_W'(arguments);
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
          mem_r[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Zero-latency read with same-cycle writeback bypass; address 0 is forced to zero.
  always_comb begin
    rdata = '0;
    ra_s  = '0;
    wa_s  = '0;
    rd_s  = '0;
    for (int j = 0; j < NREAD; j++) begin
      ra_s = raddr[j*ADDR_W +: ADDR_W];
      rd_s = mem_r[ra_s];
      for (int i = 0; i < NWRITE; i++) begin
        wa_s = waddr[i*ADDR_W +: ADDR_W];
        rd_s = (we[i] && (wa_s == ra_s)) ? wdata[i*DATA_W +: DATA_W] : rd_s;
      end
      rdata[j*DATA_W +: DATA_W] = (ra_s == ADDR_W'(REG_ZERO)) ? '0 : rd_s;
    end
  end

  assign test_result = mem_r[TEST_REG];

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .we         (we),
    .waddr      (waddr),
    .wtag       (wtag),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_tag  (issue_tag),
    .flush      (flush),
    .rbusy      (rbusy),
    .rtag       (rtag)
  );
endmodule
